// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the multiplexed 7-segment display scanner.
//   scan_state_t : scan FSM states (IDLE, BLANK, SHOW)
//   SEL_OFF()    : all-ones pattern; truncate to the digit count to get
//                  "every active-low digit enable off"
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int SEL_MAX_W = 32;

    function automatic logic [SEL_MAX_W-1:0] SEL_OFF();
        return '1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Slot counter for the display scanner: counts 0..DIV-1 while run is high and
// wraps to 0. wrap is high on the cycle the counter sits at DIV-1 and will
// return to 0 on the next edge.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous clear (holds the count at 0)
//   run  : count enable
//   cnt  : current slot position
//   wrap : terminal-count pulse (combinational from cnt/run)
// ---------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV = 8,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign wrap = run && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Time-multiplexes NUM_DIGITS BCD digits onto one 7-segment decoder. Each
// digit owns a slot of SCAN_DIV cycles; the first BLANK_CYCLES of a slot keep
// every digit off while the downstream decoder (one cycle of latency) settles
// on the new code. New data is staged in a shadow register and promoted to the
// active register at frame start so a frame never mixes old and new digits.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   enable      : scanning runs while high
//   load        : one-cycle strobe capturing digits_in / dp_in
//   digits_in   : BCD digits, digit 0 in [3:0]
//   dp_in       : decimal point requests, active-high
//   number_data : BCD code to the decoder (codes > 9 pass through)
//   smg_sel     : digit enables, active-low
//   smg_dp      : decimal point, active-low, aligned with smg_sel
//   frame_start : one-cycle pulse on the first BLANK cycle of digit 0
// All outputs are registered from next-state values, so they line up with
// the state register and change at most once per cycle.
// ---------------------------------------------------------------------------
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              number_data,
    output logic [NUM_DIGITS-1:0]   smg_sel,
    output logic                    smg_dp,
    output logic                    frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] SEL_ALL    = NUM_DIGITS'(SEL_OFF());
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t state, state_nxt;

    logic [CW-1:0] slot_cnt;
    logic          slot_wrap;
    logic          scan_run;
    logic          scan_clr;

    logic [IW-1:0] idx, idx_nxt;
    logic          fs_nxt;

    logic [4*NUM_DIGITS-1:0] shadow_digits, active_digits, active_digits_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, active_dp_nxt;

    logic [NUM_DIGITS-1:0] sel_nxt;
    logic                  dp_nxt;

    // The counter only advances once a slot is under way; the IDLE->BLANK
    // edge leaves it at 0 so that cycle is slot position 0.
    assign scan_run = enable && (state != IDLE);
    assign scan_clr = !enable;

    scan_prescaler #(
        .DIV (SCAN_DIV),
        .CW  (CW)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (scan_clr),
        .run  (scan_run),
        .cnt  (slot_cnt),
        .wrap (slot_wrap)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt         = state;
        idx_nxt           = idx;
        fs_nxt            = 1'b0;
        active_digits_nxt = active_digits;
        active_dp_nxt     = active_dp;
        sel_nxt           = SEL_ALL;
        dp_nxt            = 1'b1;

        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    fs_nxt    = 1'b1;
                end
                BLANK: begin
                    if (slot_cnt == BLANK_LAST) state_nxt = SHOW;
                end
                SHOW: begin
                    if (slot_wrap) begin
                        state_nxt = BLANK;
                        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        fs_nxt    = (idx == IDX_LAST);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // The promotion happens on the same edge that raises frame_start, so
        // digit 0's code is already on number_data in the first BLANK cycle.
        // A load sampled on that edge bypasses the shadow and lands directly.
        if (fs_nxt) begin
            active_digits_nxt = load ? digits_in : shadow_digits;
            active_dp_nxt     = load ? dp_in     : shadow_dp;
        end

        if (state_nxt == SHOW) begin
            sel_nxt[idx_nxt] = 1'b0;
            dp_nxt           = ~active_dp_nxt[idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            number_data   <= 4'd0;
            smg_sel       <= SEL_ALL;
            smg_dp        <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            active_digits <= active_digits_nxt;
            active_dp     <= active_dp_nxt;
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
            // Hold the last code while idle; the display is blanked anyway.
            if (state_nxt != IDLE) begin
                number_data <= active_digits_nxt[4*idx_nxt +: 4];
            end
            smg_sel     <= sel_nxt;
            smg_dp      <= dp_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
